// File: rtl/adc_spi_pkg.sv
// Shared ADC128S022-style SPI frame constants and FSM encodings.
// Used by both the on-chip SPI master and the ADC responder.
package adc_spi_pkg;

    localparam int FRAME_W    = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int CH_MSB     = 13;
    localparam int CH_LSB     = 11;
    localparam int CH_W       = CH_MSB - CH_LSB + 1;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic [CH_W-1:0] ch_wrap(
        input logic [CH_W-1:0] i_ch,
        input int              i_n_ch
    );
        return CH_W'(int'(i_ch) % i_n_ch);
    endfunction

endpackage

// File: rtl/adc_spi_responder_spi_in_sync.sv
// Multi-flop synchronizer for a slow pad input with
// single-cycle rise/fall strobes on the synchronized level.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_lvl;

    assign w_lvl = r_sync[SYNC_STAGES-1];

    // Reset to 0 so a line already low at release is not seen as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_hist <= w_lvl;
        end
    end

    assign o_rise = w_lvl & ~r_hist;
    assign o_fall = ~w_lvl & r_hist;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC128S022-compatible SPI slave emulator: decodes the control word and
// returns the sample of the channel addressed in the previous frame.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    output logic                   conv_start,
    output logic [2:0]             conv_ch,
    output logic [15:0]            ctrl_word,
    output logic                   frame_done,
    output logic                   frame_err
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;

    logic [SYNC_STAGES-1:0] r_mosi_sync;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (spi_sclk),
        .o_rise(w_sclk_rise),
        .o_fall(w_sclk_fall)
    );

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (spi_cs_n),
        .o_rise(w_cs_rise),
        .o_fall(w_cs_fall)
    );

    // Same depth as SCLK so MOSI is aligned with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    state_e            r_state;
    state_e            w_state_nxt;
    logic [FRAME_W-1:0] r_tx_sr;
    logic [FRAME_W-1:0] w_tx_nxt;
    logic [FRAME_W-1:0] r_rx_sr;
    logic [FRAME_W-1:0] w_rx_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_miso;
    logic              w_miso_nxt;
    logic              r_oe;
    logic              w_oe_nxt;
    logic [CH_W-1:0]   r_conv_ch;
    logic [CH_W-1:0]   w_conv_ch_nxt;
    logic [CH_W-1:0]   r_next_ch;
    logic [CH_W-1:0]   w_next_ch_nxt;
    logic [FRAME_W-1:0] r_ctrl;
    logic [FRAME_W-1:0] w_ctrl_nxt;
    logic              r_start;
    logic              w_start_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [DATA_W-1:0] w_sample;

    assign w_sample = ch_data[int'(r_next_ch)*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx_sr;
        w_rx_nxt      = r_rx_sr;
        w_cnt_nxt     = r_bit_cnt;
        w_miso_nxt    = r_miso;
        w_oe_nxt      = r_oe;
        w_conv_ch_nxt = r_conv_ch;
        w_next_ch_nxt = r_next_ch;
        w_ctrl_nxt    = r_ctrl;
        w_start_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_tx_nxt      = FRAME_W'(w_sample);
                    w_miso_nxt    = w_tx_nxt[FRAME_W-1];
                    w_oe_nxt      = 1'b1;
                    w_conv_ch_nxt = r_next_ch;
                    w_start_nxt   = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_err_nxt   = 1'b1;
                    w_miso_nxt  = 1'b0;
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_rx_nxt  = {r_rx_sr[FRAME_W-2:0], w_mosi};
                    w_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == CNT_W'(FRAME_W-1)) begin
                        w_ctrl_nxt    = w_rx_nxt;
                        w_next_ch_nxt = ch_wrap(w_rx_nxt[CH_MSB:CH_LSB], N_CH);
                        w_miso_nxt    = 1'b0;
                        w_state_nxt   = ST_HOLD;
                    end
                end else if (w_sclk_fall && r_bit_cnt != '0) begin
                    // A fall before the first rise is a CPOL=1 idle edge.
                    w_tx_nxt   = {r_tx_sr[FRAME_W-2:0], 1'b0};
                    w_miso_nxt = w_tx_nxt[FRAME_W-1];
                end
            end
            ST_HOLD: begin
                w_miso_nxt = 1'b0;
                if (w_cs_rise) begin
                    w_done_nxt  = 1'b1;
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_miso_nxt  = 1'b0;
                w_oe_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_conv_ch <= '0;
            r_next_ch <= '0;
            r_ctrl    <= '0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_tx_sr   <= w_tx_nxt;
            r_rx_sr   <= w_rx_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_miso    <= w_miso_nxt;
            r_oe      <= w_oe_nxt;
            r_conv_ch <= w_conv_ch_nxt;
            r_next_ch <= w_next_ch_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_start   <= w_start_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign conv_start  = r_start;
    assign conv_ch     = r_conv_ch;
    assign ctrl_word   = r_ctrl;
    assign frame_done  = r_done;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a bit-banged SPI master drives
// frames while a scoreboard queue holds the expected reply per frame.
module tb_adc_spi_responder;

    localparam int DATA_W = 12;
    localparam int N_CH   = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   spi_sclk;
    logic                   spi_cs_n;
    logic                   spi_mosi;
    logic                   spi_miso;
    logic                   spi_miso_oe;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic                   conv_start;
    logic [2:0]             conv_ch;
    logic [15:0]            ctrl_word;
    logic                   frame_done;
    logic                   frame_err;

    adc_spi_responder #(
        .DATA_W     (DATA_W),
        .N_CH       (N_CH),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .ch_data    (ch_data),
        .conv_start (conv_start),
        .conv_ch    (conv_ch),
        .ctrl_word  (ctrl_word),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic [15:0] miso;
        logic [15:0] mask;
        logic [2:0]  ch;
        logic [15:0] ctrl;
        int          done;
        int          err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_start  = 0;
    int          n_done   = 0;
    int          n_err    = 0;
    logic [2:0]  model_ch;
    logic [15:0] model_ctrl;

    always @(negedge clk) begin
        if (conv_start) n_start++;
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic half_period();
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] ctrl, input int nrise);
        exp_t        e;
        logic [15:0] m;
        logic [15:0] got;
        logic        tail;
        int          s0, d0, e0;
        e.miso = 16'(ch_data[int'(model_ch)*DATA_W +: DATA_W]);
        e.ch   = model_ch;
        if (nrise >= 16) begin
            e.ctrl     = ctrl;
            e.done     = 1;
            e.err      = 0;
            model_ch   = ctrl[13:11];
            model_ctrl = ctrl;
        end else begin
            e.ctrl = model_ctrl;
            e.done = 0;
            e.err  = 1;
        end
        m = 16'hFFFF;
        if (nrise < 16) m = m << (16 - nrise);
        e.mask = m;
        sb.push_back(e);
        s0   = n_start;
        d0   = n_done;
        e0   = n_err;
        got  = '0;
        tail = 1'b0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        half_period();
        for (int i = 0; i < nrise; i++) begin
            spi_mosi = (i < 16) ? ctrl[15-i] : 1'b1;
            half_period();
            spi_sclk = 1'b1;
            if (i == 0) check("oe_active", 32'(spi_miso_oe), 32'd1);
            if (i < 16) got[15-i] = spi_miso;
            else        tail = tail | spi_miso;
            half_period();
            spi_sclk = 1'b0;
        end
        half_period();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        e = sb.pop_front();
        check("miso_bits", 32'(got & e.mask), 32'(e.miso & e.mask));
        if (nrise > 16) check("miso_tail", 32'(tail), 32'd0);
        check("conv_ch", 32'(conv_ch), 32'(e.ch));
        check("ctrl_word", 32'(ctrl_word), 32'(e.ctrl));
        check("conv_start_n", 32'(n_start - s0), 32'd1);
        check("frame_done_n", 32'(n_done - d0), 32'(e.done));
        check("frame_err_n", 32'(n_err - e0), 32'(e.err));
        check("oe_idle", 32'(spi_miso_oe), 32'd0);
        check("miso_idle", 32'(spi_miso), 32'd0);
    endtask

    initial begin
        int s0;
        logic [15:0] c;
        rst_n      = 1'b0;
        spi_sclk   = 1'b0;
        spi_cs_n   = 1'b1;
        spi_mosi   = 1'b0;
        ch_data    = '0;
        model_ch   = '0;
        model_ctrl = '0;
        ch_data[0 +: DATA_W] = 12'hA5C;
        repeat (4) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_conv_ch", 32'(conv_ch), 32'd0);
        check("rst_ctrl", 32'(ctrl_word), 32'd0);
        check("rst_pulses", 32'({conv_start, frame_done, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        run_frame(16'h0000, 16);
        run_frame(16'h2800, 16);
        ch_data[5*DATA_W +: DATA_W] = 12'h3F1;
        run_frame(16'h0000, 16);

        for (int k = 0; k < N_CH; k++)
            ch_data[k*DATA_W +: DATA_W] = 12'(k * 12'h111);
        for (int j = 1; j <= 8; j++) begin
            c = 16'((j % 8) << 11);
            run_frame(c, 16);
        end

        run_frame(16'h3000, 16);
        run_frame(16'h1800, 9);
        run_frame(16'h1000, 16);

        run_frame(16'h3923, 18);

        ch_data[0 +: DATA_W] = 12'hBEE;
        s0 = n_start;
        @(negedge clk);
        spi_cs_n = 1'b0;
        half_period();
        for (int i = 0; i < 7; i++) begin
            spi_mosi = 1'b1;
            half_period();
            spi_sclk = 1'b1;
            half_period();
            spi_sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
        check("mid_rst_miso", 32'(spi_miso), 32'd0);
        check("mid_rst_conv_ch", 32'(conv_ch), 32'd0);
        check("mid_rst_ctrl", 32'(ctrl_word), 32'd0);
        check("mid_rst_pulses", 32'({conv_start, frame_done, frame_err}), 32'd0);
        model_ch   = '0;
        model_ctrl = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("cs_low_at_release_oe", 32'(spi_miso_oe), 32'd0);
        check("cs_low_at_release_start", 32'(n_start - s0), 32'd1);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        run_frame(16'h0000, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI slave that answers the on-chip ADC SPI master with the ADC128S022 frame format.
- Serves as a bit-exact, synthesizable ADC emulator for the fridge controller: FPGA prototype loopback, self-test mode and chip-level benches.
- Oversamples SCLK/CS_N/MOSI in the 10 MHz clk domain and decodes the 16-bit control word.
- Returns the 12-bit sample of the channel addressed in the previous frame on MISO, with 4 leading zeros, MSB first.

Parameters:
- DATA_W, 12, sample width returned per frame
- N_CH, 8, number of emulated channels; channel address is 3 bits
- SYNC_STAGES, 2, synchronizer depth on spi_sclk/spi_cs_n/spi_mosi (minimum 2)

Ports:
- clk  in  1  system clock, 10 MHz
- rst_n  in  1  asynchronous active-low reset
- spi_sclk  in  1  SPI clock from master, ≤1 MHz, idle low
- spi_cs_n  in  1  chip select from master, active low
- spi_mosi  in  1  master data out; sampled on SCLK rising edge
- spi_miso  out  1  slave data out; changes after SCLK falling edge
- spi_miso_oe  out  1  high while a frame is active (pad enable)
- ch_data  in  N_CH*DATA_W  packed samples; channel k at [k*DATA_W +: DATA_W]
- conv_start  out  1  one-clk pulse at frame start
- conv_ch  out  3  channel being returned in the current frame
- ctrl_word  out  16  last complete received control word
- frame_done  out  1  one-clk pulse on a good frame end
- frame_err  out  1  one-clk pulse on a short frame end

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, conv_start=0, conv_ch=0, ctrl_word=0, frame_done=0, frame_err=0, next_ch=0, bit_cnt=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synced values plus one history flop.
  - Required SCLK half-period is ≥ SYNC_STAGES+2 clk (4 clk at defaults; 1 MHz gives 5).
- FSM states: IDLE, ACTIVE, HOLD.
- IDLE, on synced cs_n fall:
  - tx_sr <= {4'b0, ch_data[next_ch]}; ch_data is snapshotted at this cycle only.
  - conv_ch <= next_ch; conv_start pulses.
  - spi_miso_oe=1; spi_miso = tx_sr[15] = 0.
  - bit_cnt=0; go to ACTIVE.
- ACTIVE, on SCLK rise:
  - rx_sr <= {rx_sr[14:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches 16: ctrl_word <= new rx_sr; next_ch <= new rx_sr[13:11]; go to HOLD.
- ACTIVE, on SCLK fall:
  - Only if bit_cnt ≥ 1: tx_sr shifts left with 0 fill; spi_miso <= new tx_sr[15].
  - A fall before the first rise is ignored (CPOL=1 tolerance).
- MISO latency: updates 1 clk after the synced fall is detected, i.e. SYNC_STAGES+1 clk after the pad edge, so it is stable before the next rise.
- HOLD:
  - Further SCLK edges are ignored; spi_miso=0 (the 16th-bit fall drives 0).
  - On cs_n rise: frame_done pulses; oe=0; go to IDLE.
- cs_n rise in ACTIVE (bit_cnt<16):
  - frame_err pulses; ctrl_word and next_ch stay unchanged; spi_miso=0; oe=0; go to IDLE.
- cs_n rise and SCLK edge detected in the same clk: the cs_n rise wins and the edge is discarded.
- cs_n fall and SCLK edge detected in the same clk: the frame starts and the edge is discarded.
- Channel address bits 13:11 are taken modulo N_CH. The other control bits are stored but ignored.
- Channel addressed in frame n is returned in frame n+1. After reset the first frame returns channel 0.
- Async reset mid-frame forces reset values immediately. The next frame is recognised only after a new cs_n fall; CS_N already low at reset release does not start a frame.
- The spi_mosi, spi_miso_oe and ch_data values are don't-care outside their documented sampling points.

Decomposition:
- Package adc_spi_pkg: frame length 16, leading-zero count 4, channel field position 13:11, FSM state encodings. The existing SPI master shares this package.
- One sub-module, spi_in_sync: parameterized SYNC_STAGES synchronizer plus rise/fall detect. Instantiated for sclk and cs_n; a plain synchronizer is used for mosi.

Test Plan:
- Reset, ch_data[0]=12'hA5C, frame with control 16'h0000 -> MISO bits 0000_1010_0101_1100, conv_ch=0, frame_done pulse, ctrl_word=16'h0000.
- Frame with control 16'h2800 (ch5), then a second frame with ch_data[5]=12'h3F1 -> second frame returns 0000_0011_1111_0001 and conv_ch=5.
- Full 8-frame sweep addressing ch 1..7,0 with ch_data[k]=k*12'h111 -> each frame returns the previous frame's channel value; no frame_err.
- cs_n raised after 9 SCLK rises -> frame_err pulse, ctrl_word unchanged, next frame returns same channel as before.
- 18 SCLK pulses in one frame -> edges 17-18 ignored, MISO=0 after bit 16, frame_done pulse, ctrl_word = first 16 bits.
- rst_n asserted mid-frame at bit 7 -> all outputs at reset values the same cycle; next full frame returns channel 0 data.
